i2c_s: RTL

I2C_S -- requirements
Module: i2c_s

---
 rtl/i2c_s.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_s.sv
// I2C target with fixed 7-bit address: receives written bytes, returns tx_data on reads.
// sclk/sda are oversampled on clk through 2-FF synchronizers; sda is open-drain.
module i2c_s #(
  parameter logic [6:0] SLV_ADDR = 7'h49
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0] scl_q, scl_d;
  logic [2:0] sdai_q, sdai_d;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       done_q, done_d;
  logic       oe_q, oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;

  logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

  assign sda_bit   = sdai_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  // Both sclk samples high, so sda edges while sclk is low never qualify
  assign start_det = scl_q[1] & scl_q[2] & sdai_q[2] & ~sdai_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sdai_q[2] & sdai_q[1];

  always_comb begin
    scl_d      = {scl_q[1:0], sclk};
    sdai_d     = {sdai_q[1:0], sda};
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    done_d     = done_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;

    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = 3'd0;
    end else if (start_det) begin
      // busy is kept so a repeated START to us does not glitch it low
      state_d = ADDR;
      oe_d    = 1'b0;
      done_d  = 1'b0;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], sda_bit};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (sr_q[6:0] == SLV_ADDR) begin
                rw_d   = sda_bit;
                busy_d = 1'b1;
                done_d = 1'b1;
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end else if (scl_fall && done_q) begin
            oe_d    = 1'b1;
            done_d  = 1'b0;
            state_d = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            oe_d  = 1'b0;
            cnt_d = 3'd0;
            if (rw_q) begin
              tx_req_d = 1'b1;
              sr_d     = tx_data;
              oe_d     = ~tx_data[7];
              state_d  = TX;
            end else begin
              state_d = RX;
            end
          end
        end
        RX: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], sda_bit};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = {sr_q[6:0], sda_bit};
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            oe_d    = 1'b1;
            done_d  = 1'b0;
            state_d = RX_ACK;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = RX;
          end
        end
        TX: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall) begin
            if (done_q) begin
              oe_d    = 1'b0;
              done_d  = 1'b0;
              state_d = TX_ACK;
            end else begin
              sr_d = {sr_q[6:0], 1'b0};
              oe_d = ~sr_q[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_bit) done_d = 1'b1;
            else          state_d = WAIT_STOP;
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            cnt_d    = 3'd0;
            tx_req_d = 1'b1;
            sr_d     = tx_data;
            oe_d     = ~tx_data[7];
            state_d  = TX;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q      <= 3'b111;
      sdai_q     <= 3'b111;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      sr_q       <= 8'h00;
      done_q     <= 1'b0;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_q      <= scl_d;
      sdai_q     <= sdai_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      done_q     <= done_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  assign sda      = oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign rw       = rw_q;
  assign busy     = busy_q;

endmodule
